// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state and
// command-owner encodings, plus the access size used for instruction fetch.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MARB_IDLE   = 2'b00,
    MARB_BUSY_I = 2'b01,
    MARB_BUSY_D = 2'b10
  } marb_state_t;

  typedef enum logic {
    MARB_OWN_IF = 1'b0,
    MARB_OWN_D  = 1'b1
  } marb_owner_t;

  // Fetches are always full-word reads (LW encoding).
  localparam logic [2:0] MARB_FETCH_FUNCT3 = 3'b010;

  function automatic marb_owner_t marb_owner_of(input marb_state_t s);
    return (s == MARB_BUSY_D) ? MARB_OWN_D : MARB_OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_run_cnt.sv
// Counts consecutive data grants made while a fetch is waiting and raises
// force_if once the run reaches MAX_DATA_RUN, so the next window goes to fetch.
module mem_arb_run_cnt #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic window,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_if
);

  localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);

  logic [CNT_W-1:0] cnt;

  // Run length only moves at grant windows; a fetch grant or an idle fetch
  // side restarts it. It never passes MAX_DATA_RUN because force_if wins there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (window) begin
      if (if_gnt || !if_req) cnt <= '0;
      else if (d_gnt)        cnt <= cnt + CNT_W'(1);
    end
  end

  assign force_if = if_req && (cnt == CNT_W'(MAX_DATA_RUN));

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing the single-ported unified memory between
// instruction fetch and data access. Data wins collisions; one command is in
// flight at a time and a new grant may be issued in the ack cycle.
// Optional feature: define MEM_ARB_FAIRNESS_EN to bound how many data grants
// in a row may pass a waiting fetch (MAX_DATA_RUN).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  marb_state_t       state, state_nxt;
  logic              window;
  logic              force_if;
  logic              cmd_we;
  logic [2:0]        cmd_funct3;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // mem_ack only means something while a command is outstanding.
  assign window = (state == MARB_IDLE) || mem_ack;

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_run_cnt #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .window   (window),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt),
    .force_if (force_if)
  );
`else
  localparam int unused_max_data_run = MAX_DATA_RUN;
  assign force_if = 1'b0;
`endif

  // State register; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MARB_IDLE;
    else      state <= state_nxt;
  end

  // Grant decision and next state; data first unless fairness forces a fetch.
  always_comb begin
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    state_nxt = state;
    if (window) begin
      state_nxt = MARB_IDLE;
      if (d_req && !force_if) begin
        d_gnt     = 1'b1;
        state_nxt = MARB_BUSY_D;
      end else if (if_req) begin
        if_gnt    = 1'b1;
        state_nxt = MARB_BUSY_I;
      end
    end
  end

  // Command register captures the granted requester's fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_we     <= 1'b0;
      cmd_funct3 <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else if (d_gnt) begin
      cmd_we     <= d_we;
      cmd_funct3 <= d_funct3;
      cmd_addr   <= d_addr;
      cmd_wdata  <= d_wdata;
    end else if (if_gnt) begin
      cmd_we     <= 1'b0;
      cmd_funct3 <= MARB_FETCH_FUNCT3;
      cmd_addr   <= if_addr;
      cmd_wdata  <= '0;
    end
  end

  // Response register: one-cycle rvalid to the command's owner after mem_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if ((state != MARB_IDLE) && mem_ack) begin
        if (marb_owner_of(state) == MARB_OWN_D) begin
          d_rvalid <= 1'b1;
          d_rdata  <= cmd_we ? '0 : mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

  assign busy       = (state != MARB_IDLE);
  assign mem_req    = busy;
  assign mem_we     = cmd_we;
  assign mem_funct3 = cmd_funct3;
  assign mem_addr   = cmd_addr;
  assign mem_wdata  = cmd_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [2:0]    d_funct3;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_funct3;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAXR)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: the one outstanding command, pending responses, fairness run.
  bit            m_busy, m_is_d, m_we;
  logic [2:0]    m_f3;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            e_iv, e_dv;
  logic [DW-1:0] e_ird, e_drd;
  int            m_run;
  bit            last_d, last_i;

  // Values sampled from the DUT in the most recent cycle.
  logic          s_ig, s_dg, s_mreq, s_mwe, s_iv, s_dv;
  logic [2:0]    s_mf3;
  logic [AW-1:0] s_maddr;
  logic [DW-1:0] s_mwd, s_ird, s_drd;

  logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_d = 0; m_we = 0; m_f3 = '0; m_addr = '0; m_wdata = '0;
    e_iv = 0; e_dv = 0; e_ird = '0; e_drd = '0; m_run = 0;
    last_d = 0; last_i = 0;
  endtask

  // One clock: check at negedge against the model, advance model at posedge.
  task automatic cycle();
    bit win, frc, ed, ei;
    @(negedge clk);
    s_ig = if_gnt; s_dg = d_gnt; s_mreq = mem_req; s_mwe = mem_we;
    s_mf3 = mem_funct3; s_maddr = mem_addr; s_mwd = mem_wdata;
    s_iv = if_rvalid; s_dv = d_rvalid; s_ird = if_rdata; s_drd = d_rdata;
    win = !m_busy || mem_ack;
    frc = FAIR && (m_run >= MAXR) && if_req;
    ed  = win && d_req && !frc;
    ei  = win && if_req && !ed;
    chk("d_gnt", s_dg, ed);
    chk("if_gnt", s_ig, ei);
    chk("mem_req", s_mreq, m_busy);
    chk("busy", busy, m_busy);
    if (m_busy) begin
      chk("mem_addr", s_maddr, m_addr);
      chk("mem_we", s_mwe, m_we);
      chk("mem_funct3", s_mf3, m_f3);
      if (m_we) chk("mem_wdata", s_mwd, m_wdata);
    end
    chk("if_rvalid", s_iv, e_iv);
    chk("d_rvalid", s_dv, e_dv);
    if (e_iv) chk("if_rdata", s_ird, e_ird);
    if (e_dv) chk("d_rdata", s_drd, e_drd);
    @(posedge clk);
    e_iv = m_busy && mem_ack && !m_is_d;
    e_dv = m_busy && mem_ack && m_is_d;
    if (e_iv) e_ird = mem_rdata;
    if (e_dv) e_drd = m_we ? '0 : mem_rdata;
    if (win) begin
      if (ei || !if_req) m_run = 0;
      else if (ed)       m_run++;
      m_busy = ed || ei;
      m_is_d = ed;
      if (ed) begin
        m_we = d_we; m_f3 = d_funct3; m_addr = d_addr; m_wdata = d_wdata;
      end else if (ei) begin
        m_we = 0; m_f3 = 3'b010; m_addr = if_addr; m_wdata = '0;
      end
    end
    last_d = ed;
    last_i = ei;
    #1;
  endtask

  task automatic rand_cycle();
    if (!d_req) begin
      if ($urandom_range(0, 2) == 0) begin
        d_req    = 1'b1;
        d_we     = ($urandom_range(0, 1) == 1);
        d_funct3 = d_we ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
        d_addr   = $urandom;
        d_wdata  = $urandom;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      d_req = 1'b0;
    end
    if (!if_req) begin
      if ($urandom_range(0, 1) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      if_req = 1'b0;
    end
    mem_ack   = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
    mem_rdata = $urandom;
    cycle();
    if (last_d) d_req = 1'b0;
    if (last_i) if_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_funct3 = '0; d_wdata = '0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst busy", busy, 0);
    chk("rst rvalid", {if_rvalid, d_rvalid}, 0);
    chk("rst rdata", if_rdata | d_rdata, 0);
    chk("rst cmd", {mem_we, mem_funct3} | mem_addr | mem_wdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: fetch only, ack one cycle after mem_req
    if_req = 1; if_addr = 32'h10;
    cycle();
    chk("t1 if_gnt", s_ig, 1);
    if_req = 0;
    cycle();
    chk("t1 mem_req", s_mreq, 1);
    chk("t1 mem_addr", s_maddr, 32'h10);
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    cycle();
    chk("t1 mem_req held", s_mreq, 1);
    mem_ack = 0;
    cycle();
    chk("t1 if_rvalid", s_iv, 1);
    chk("t1 if_rdata", s_ird, 32'h0050_0093);

    // 2: collision, data first, fetch granted in the ack cycle
    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h40;
    cycle();
    chk("t2 d_gnt", s_dg, 1);
    chk("t2 if_gnt low", s_ig, 0);
    d_req = 0;
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    cycle();
    chk("t2 if_gnt in ack", s_ig, 1);
    if_req = 0;
    mem_rdata = 32'h0000_0013;
    cycle();
    chk("t2 d_rvalid", s_dv, 1);
    chk("t2 d_rdata", s_drd, 32'hDEAD_BEEF);
    chk("t2 fetch addr", s_maddr, 32'h80);
    mem_ack = 0;
    cycle();
    chk("t2 if_rvalid", s_iv, 1);
    chk("t2 if_rdata", s_ird, 32'h13);

    // 3: byte store held for three cycles
    d_req = 1; d_we = 1; d_funct3 = 3'b000; d_addr = 32'h21; d_wdata = 32'hA5;
    cycle();
    chk("t3 d_gnt", s_dg, 1);
    d_req = 0;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      cycle();
      chk("t3 mem_we", s_mwe, 1);
      chk("t3 mem_funct3", s_mf3, 0);
      chk("t3 mem_wdata", s_mwd, 32'hA5);
      chk("t3 mem_addr", s_maddr, 32'h21);
    end
    mem_ack = 0;
    cycle();
    chk("t3 d_rvalid", s_dv, 1);
    chk("t3 d_rdata zero", s_drd, 0);

    // 4: reset while a fetch is outstanding
    if_req = 1; if_addr = 32'h30;
    cycle();
    if_req = 0;
    cycle();
    chk("t4 mem_req before rst", s_mreq, 1);
    #2 rst = 1'b0;
    #1;
    chk("t4 mem_req async", mem_req, 0);
    chk("t4 busy async", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if_req = 1; if_addr = 32'h34;
    cycle();
    chk("t4 if_gnt after rst", s_ig, 1);
    chk("t4 no rvalid", {s_iv, s_dv}, 0);
    if_req = 0; mem_ack = 1;
    cycle();
    mem_ack = 0;
    cycle();

    // 6: stray ack while idle, and a fetch withdrawn before grant
    mem_ack = 1;
    cycle();
    cycle();
    chk("t6 stray rvalid", {s_iv, s_dv}, 0);
    chk("t6 stray mem_req", s_mreq, 0);
    mem_ack = 0;
    d_req = 1; d_we = 0; d_funct3 = 3'b100; d_addr = 32'h200;
    cycle();
    d_req = 0; if_req = 1; if_addr = 32'h44;
    cycle();
    chk("t6 no gnt while busy", s_ig, 0);
    if_req = 0; mem_ack = 1;
    cycle();
    chk("t6 withdrawn no gnt", s_ig, 0);
    mem_ack = 0;
    cycle();
    chk("t6 idle after withdraw", s_mreq, 0);

    // 5: data and fetch both held, ack every cycle
    cycle();
    d_req = 1; if_req = 1; d_we = 0; mem_ack = 1;
    for (int k = 0; k < 10; k++) begin
      d_addr = 32'h1000 + k * 4; if_addr = 32'h2000 + k * 4; mem_rdata = $urandom;
      cycle();
      chk("t5 if_gnt pattern", s_ig, (FAIR && (k % 5 == 4)) ? 1 : 0);
    end
    d_req = 0; if_req = 0;
    cycle();
    mem_ack = 0;
    cycle();

    for (int n = 0; n < 3000; n++) rand_cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
